regfile: RTL and testbench
==========================

Name: regfile

Overview:
- 32 x 32-bit integer register file for the rv32i core.
- Serves the decode stage's two combinational read requests and accepts one synchronous write per cycle from the write-back stage.
- Hardwires x0 to zero.
- Provides same-cycle write-to-read bypass, so decode never sees stale data for a register being written back in the current cycle.

Parameters:
- RADDR_W, 5, register address width.
- RDATA_W, 32, register data width.
- NUM_REGS, 32, number of architectural registers (equals 2**RADDR_W).

Ports:
- clk_in  input  1  core clock; all state updates on rising edge.
- reset_in  input  1  asynchronous, active-high reset.
- we_in  input  1  write enable from write-back (WRITE_ENABLE = 1).
- waddr_in  input  RADDR_W  write register index.
- wdata_in  input  RDATA_W  write data.
- reg1_raddr_in  input  RADDR_W  read port 1 index from decode.
- reg1_renable_in  input  1  read port 1 enable (READ_ENABLE = 1).
- reg2_raddr_in  input  RADDR_W  read port 2 index from decode.
- reg2_renable_in  input  1  read port 2 enable.
- rdata1_out  output  RDATA_W  read port 1 data.
- rdata2_out  output  RDATA_W  read port 2 data.

Behaviour:
- Storage: regs[1..NUM_REGS-1], RDATA_W bits each. x0 has no storage.
- Reset (async, reset_in = 1):
  - all stored registers clear to 0 immediately.
  - both read outputs read 0 while reset is asserted, regardless of address or enable.
  - writes are ignored while reset is asserted.
  - reset deasserting mid-stream: the first rising edge with reset_in = 0 performs a normal write.
- Write (sequential):
  - on posedge clk_in, if we_in = 1 and waddr_in != 0, then regs[waddr_in] <= wdata_in.
  - a write to x0 is silently dropped.
  - written data is visible through storage from the next cycle.
- Read (combinational, zero latency), evaluated per port in this priority order:
  1. reset_in = 1 -> 0.
  2. renable = 0 -> 0.
  3. raddr = 0 -> 0, even if we_in = 1 and waddr_in = 0.
  4. we_in = 1 and waddr_in = raddr -> wdata_in (same-cycle bypass).
  5. Otherwise -> regs[raddr].
- Both ports are independent; both may read the same register, including one being bypassed.
- Only one write port exists. No write-write conflicts.
- No X propagation: every output is driven in every branch.
- Read and write of the same register in the same cycle: the read returns the new value (bypass); storage is updated at the edge.

Optional Feature:
- Macro: REGFILE_DEBUG_EN.
- Defined: adds ports dbg_raddr_in (input, RADDR_W) and dbg_rdata_out (output, RDATA_W).
  - dbg_rdata_out is a combinational read of storage with no bypass and no enable; x0 reads 0.
  - Also adds wr_count_out (output, 32), which increments on every accepted write (we_in = 1, waddr_in != 0, not in reset) and clears on reset.
- Undefined: these ports and the counter do not exist. Core behaviour is identical either way.

Decomposition:
- Shared defines header (the existing defines file) supplies RADDR_WIDTH, RDATA_WIDTH, ZERO_REG, ZERO, READ_ENABLE/READ_DISABLE and WRITE_ENABLE/WRITE_DISABLE. Port widths use these.
- Sub-module regfile_rd_port: one combinational read mux implementing the priority above. It is instantiated twice, plus once with bypass disabled for the debug port.
- Storage and write logic stay in the top module.

Test Plan:
- Reset check: assert reset_in mid-cycle after writing x5 = 0xDEADBEEF -> rdata1_out for x5 = 0 immediately (async). After release, x5 still reads 0.
- Write then read: write x3 = 0x12345678 at cycle N; in cycle N+1 read port 1 addr 3, enable 1 -> 0x12345678. With enable 0 -> 0.
- Same-cycle bypass: x7 holds 0x1. In one cycle drive we_in = 1, waddr 7, wdata 0xA5A5A5A5, and read both ports at addr 7 -> both outputs 0xA5A5A5A5 in that cycle. Next cycle without the write -> 0xA5A5A5A5 from storage.
- x0 hardwire: write x0 = 0xFFFFFFFF and read x0 on both ports the same cycle and the next cycle -> 0 throughout. With REGFILE_DEBUG_EN, wr_count_out does not increment.
- Sweep: write regs 1..31 with value (i * 0x01010101) on consecutive cycles, then read all pairs (i, 32-i) -> exact values. Under REGFILE_DEBUG_EN, wr_count_out = 31 and dbg_rdata_out matches.
- Write during reset: hold reset_in = 1 with we_in = 1, waddr 9, wdata 0x55 for 3 edges, then release -> x9 reads 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants and small decode helpers for the rv32i core.
// Optional debug port and write counter are enabled with REGFILE_DEBUG_EN.
package regfile_pkg;

    localparam int RADDR_WIDTH = 5;
    localparam int RDATA_WIDTH = 32;
    localparam int NUM_REGS    = 32;

    localparam logic [RADDR_WIDTH-1:0] ZERO_REG = 5'd0;
    localparam logic [RDATA_WIDTH-1:0] ZERO     = 32'd0;

    localparam logic READ_ENABLE   = 1'b1;
    localparam logic READ_DISABLE  = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    // A write only commits when enabled and not aimed at the hardwired zero register.
    function automatic logic write_accepted(input logic we, input logic [RADDR_WIDTH-1:0] waddr);
        return (we != WRITE_DISABLE) && (waddr != ZERO_REG);
    endfunction

    function automatic logic write_hits(input logic we, input logic [RADDR_WIDTH-1:0] waddr,
                                        input logic [RADDR_WIDTH-1:0] raddr);
        return (we == WRITE_ENABLE) && (waddr == raddr);
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: reset, enable, x0, bypass, then storage, in that priority.
// Built with REGFILE_DEBUG_EN the top also uses this with bypass disabled for the debug port.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter bit BYPASS_EN = 1'b1,
    parameter int RADDR_W   = RADDR_WIDTH,
    parameter int RDATA_W   = RDATA_WIDTH,
    parameter int NUM_REGS  = 2 ** RADDR_W
) (
    input  logic                               reset,
    input  logic                               renable,
    input  logic [RADDR_W-1:0]                 raddr,
    input  logic                               we,
    input  logic [RADDR_W-1:0]                 waddr,
    input  logic [RDATA_W-1:0]                 wdata,
    input  logic [NUM_REGS-1:0][RDATA_W-1:0]   regs,
    output logic [RDATA_W-1:0]                 rdata
);

    // Read mux; every branch drives rdata so nothing undefined leaks to decode.
    always_comb begin
        rdata = ZERO;
        if (reset) begin
            rdata = ZERO;
        end else if (renable == READ_DISABLE) begin
            rdata = ZERO;
        end else if (raddr == ZERO_REG) begin
            rdata = ZERO;
        end else if (BYPASS_EN && write_hits(we, waddr, raddr)) begin
            rdata = wdata;
        end else begin
            rdata = regs[raddr];
        end
    end

endmodule

// File: rtl/regfile.sv
// 32 x 32-bit rv32i integer register file: two bypassed read ports, one write port, x0 = 0.
// Define REGFILE_DEBUG_EN to add dbg_raddr_in/dbg_rdata_out and the wr_count_out counter.
module regfile
    import regfile_pkg::*;
#(
    parameter int RADDR_W  = RADDR_WIDTH,
    parameter int RDATA_W  = RDATA_WIDTH,
    parameter int NUM_REGS = 2 ** RADDR_W
) (
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic               we_in,
    input  logic [RADDR_W-1:0] waddr_in,
    input  logic [RDATA_W-1:0] wdata_in,
    input  logic [RADDR_W-1:0] reg1_raddr_in,
    input  logic               reg1_renable_in,
    input  logic [RADDR_W-1:0] reg2_raddr_in,
    input  logic               reg2_renable_in,
    output logic [RDATA_W-1:0] rdata1_out,
    output logic [RDATA_W-1:0] rdata2_out
`ifdef REGFILE_DEBUG_EN
    ,
    input  logic [RADDR_W-1:0] dbg_raddr_in,
    output logic [RDATA_W-1:0] dbg_rdata_out,
    output logic [31:0]        wr_count_out
`endif
);

    logic [NUM_REGS-1:1][RDATA_W-1:0] regs_r;
    logic [NUM_REGS-1:0][RDATA_W-1:0] regs_s;

    // x0 has no flops; the read view simply pins slot 0 to zero.
    assign regs_s = {regs_r, ZERO};

    // Storage update: one write per cycle, writes to x0 and writes during reset dropped.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            regs_r <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (write_accepted(we_in, waddr_in) && (waddr_in == RADDR_W'(i))) begin
                    regs_r[i] <= wdata_in;
                end
            end
        end
    end

    regfile_rd_port #(
        .BYPASS_EN (1'b1),
        .RADDR_W   (RADDR_W),
        .RDATA_W   (RDATA_W),
        .NUM_REGS  (NUM_REGS)
    ) u_rd_port1 (
        .reset   (reset_in),
        .renable (reg1_renable_in),
        .raddr   (reg1_raddr_in),
        .we      (we_in),
        .waddr   (waddr_in),
        .wdata   (wdata_in),
        .regs    (regs_s),
        .rdata   (rdata1_out)
    );

    regfile_rd_port #(
        .BYPASS_EN (1'b1),
        .RADDR_W   (RADDR_W),
        .RDATA_W   (RDATA_W),
        .NUM_REGS  (NUM_REGS)
    ) u_rd_port2 (
        .reset   (reset_in),
        .renable (reg2_renable_in),
        .raddr   (reg2_raddr_in),
        .we      (we_in),
        .waddr   (waddr_in),
        .wdata   (wdata_in),
        .regs    (regs_s),
        .rdata   (rdata2_out)
    );

`ifdef REGFILE_DEBUG_EN
    logic [31:0] wr_count_r;

    regfile_rd_port #(
        .BYPASS_EN (1'b0),
        .RADDR_W   (RADDR_W),
        .RDATA_W   (RDATA_W),
        .NUM_REGS  (NUM_REGS)
    ) u_rd_port_dbg (
        .reset   (reset_in),
        .renable (READ_ENABLE),
        .raddr   (dbg_raddr_in),
        .we      (we_in),
        .waddr   (waddr_in),
        .wdata   (wdata_in),
        .regs    (regs_s),
        .rdata   (dbg_rdata_out)
    );

    // Count of writes that actually landed in storage since the last reset.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            wr_count_r <= 32'd0;
        end else if (write_accepted(we_in, waddr_in)) begin
            wr_count_r <= wr_count_r + 32'd1;
        end
    end

    assign wr_count_out = wr_count_r;
`endif

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: stimulus pushes expected reads, a negedge monitor pops and compares.
// Build with REGFILE_DEBUG_EN to also check the debug read port and write counter.
module tb_regfile;

    logic        clk             = 1'b0;
    logic        reset_in        = 1'b0;
    logic        we_in           = 1'b0;
    logic [4:0]  waddr_in        = 5'd0;
    logic [31:0] wdata_in        = 32'd0;
    logic [4:0]  reg1_raddr_in   = 5'd0;
    logic        reg1_renable_in = 1'b0;
    logic [4:0]  reg2_raddr_in   = 5'd0;
    logic        reg2_renable_in = 1'b0;
    logic [31:0] rdata1_out;
    logic [31:0] rdata2_out;
`ifdef REGFILE_DEBUG_EN
    logic [4:0]  dbg_raddr_in    = 5'd0;
    logic [31:0] dbg_rdata_out;
    logic [31:0] wr_count_out;
`endif

    always #5 clk = ~clk;

    regfile dut (
        .clk_in          (clk),
        .reset_in        (reset_in),
        .we_in           (we_in),
        .waddr_in        (waddr_in),
        .wdata_in        (wdata_in),
        .reg1_raddr_in   (reg1_raddr_in),
        .reg1_renable_in (reg1_renable_in),
        .reg2_raddr_in   (reg2_raddr_in),
        .reg2_renable_in (reg2_renable_in),
        .rdata1_out      (rdata1_out),
        .rdata2_out      (rdata2_out)
`ifdef REGFILE_DEBUG_EN
        ,
        .dbg_raddr_in    (dbg_raddr_in),
        .dbg_rdata_out   (dbg_rdata_out),
        .wr_count_out    (wr_count_out)
`endif
    );

    typedef struct {
        string       name;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] edbg;
        logic [31:0] ecnt;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [0:31];
    logic [31:0] exp_cnt;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        exp_cnt = 32'd0;
    endfunction

    // Reference read built directly from the read-priority rules.
    function automatic logic [31:0] ref_read(input logic [4:0] a, input logic en);
        if (reset_in) return 32'd0;
        if (!en) return 32'd0;
        if (a == 5'd0) return 32'd0;
        if (we_in && waddr_in == a) return wdata_in;
        return model[a];
    endfunction

    task automatic step(input string nm, input logic rst, input logic late_rst,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] a1, input logic e1, input logic [4:0] a2, input logic e2);
        exp_t        it;
        logic [4:0]  da;
        reset_in        = late_rst ? 1'b0 : rst;
        we_in           = we;
        waddr_in        = wa;
        wdata_in        = wd;
        reg1_raddr_in   = a1;
        reg1_renable_in = e1;
        reg2_raddr_in   = a2;
        reg2_renable_in = e2;
        da              = 5'($urandom);
`ifdef REGFILE_DEBUG_EN
        dbg_raddr_in    = da;
`endif
        if (late_rst) begin
            #2;
            reset_in = 1'b1;
        end
        if (reset_in) clear_model();
        it.name = nm;
        it.e1   = ref_read(a1, e1);
        it.e2   = ref_read(a2, e2);
        it.edbg = (reset_in || da == 5'd0) ? 32'd0 : model[da];
        it.ecnt = exp_cnt;
        sb.push_back(it);
        @(posedge clk);
        if (!reset_in && we_in && waddr_in != 5'd0) begin
            model[waddr_in] = wdata_in;
            exp_cnt         = exp_cnt + 32'd1;
        end
        #1;
    endtask

    // Monitor: the read outputs are valid every cycle, so compare mid-cycle on the falling edge.
    always @(negedge clk) begin
        exp_t it;
        if (sb.size() > 0) begin
            it = sb.pop_front();
            check({it.name, ".rdata1"}, rdata1_out, it.e1);
            check({it.name, ".rdata2"}, rdata2_out, it.e2);
`ifdef REGFILE_DEBUG_EN
            check({it.name, ".dbg_rdata"}, dbg_rdata_out, it.edbg);
            check({it.name, ".wr_count"}, wr_count_out, it.ecnt);
`endif
        end
    end

    initial begin
        logic [4:0]  wa;
        logic [4:0]  a1;
        logic [4:0]  a2;
        clear_model();
        #1;
        reset_in = 1'b1;
        @(posedge clk);
        #1;

        step("reset",      1'b1, 1'b0, 1'b1, 5'd5, 32'hFFFF_FFFF, 5'd5, 1'b1, 5'd5, 1'b1);
        step("wr_x5",      1'b0, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd1, 1'b1, 5'd2, 1'b1);
        step("rd_x5",      1'b0, 1'b0, 1'b0, 5'd0, 32'd0,         5'd5, 1'b1, 5'd5, 1'b1);
        step("async_rst",  1'b0, 1'b1, 1'b0, 5'd0, 32'd0,         5'd5, 1'b1, 5'd5, 1'b1);
        step("post_rst",   1'b0, 1'b0, 1'b0, 5'd0, 32'd0,         5'd5, 1'b1, 5'd5, 1'b1);
        step("wr_x3",      1'b0, 1'b0, 1'b1, 5'd3, 32'h1234_5678, 5'd0, 1'b0, 5'd0, 1'b0);
        step("rd_x3_en",   1'b0, 1'b0, 1'b0, 5'd0, 32'd0,         5'd3, 1'b1, 5'd3, 1'b0);
        step("wr_x7",      1'b0, 1'b0, 1'b1, 5'd7, 32'h0000_0001, 5'd0, 1'b0, 5'd0, 1'b0);
        step("bypass_x7",  1'b0, 1'b0, 1'b1, 5'd7, 32'hA5A5_A5A5, 5'd7, 1'b1, 5'd7, 1'b1);
        step("stored_x7",  1'b0, 1'b0, 1'b0, 5'd7, 32'd0,         5'd7, 1'b1, 5'd7, 1'b1);
        step("wr_x0",      1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 1'b1, 5'd0, 1'b1);
        step("rd_x0",      1'b0, 1'b0, 1'b0, 5'd0, 32'd0,         5'd0, 1'b1, 5'd0, 1'b1);

        step("sweep_rst",  1'b1, 1'b0, 1'b0, 5'd0, 32'd0,         5'd0, 1'b0, 5'd0, 1'b0);
        for (int i = 1; i < 32; i++) begin
            step("sweep_wr", 1'b0, 1'b0, 1'b1, 5'(i), 32'(i) * 32'h0101_0101, 5'd0, 1'b0, 5'd0, 1'b0);
        end
        for (int i = 1; i < 32; i++) begin
            step("sweep_rd", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 1'b1, 5'(32 - i), 1'b1);
        end

        for (int i = 0; i < 3; i++) begin
            step("wr_in_rst", 1'b1, 1'b0, 1'b1, 5'd9, 32'h0000_0055, 5'd9, 1'b1, 5'd9, 1'b1);
        end
        step("rd_x9",      1'b0, 1'b0, 1'b0, 5'd0, 32'd0,         5'd9, 1'b1, 5'd9, 1'b1);

        for (int n = 0; n < 400; n++) begin
            wa = 5'($urandom);
            a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            step("random", ($urandom_range(0, 49) == 0), 1'b0, 1'($urandom), wa, $urandom,
                 a1, ($urandom_range(0, 7) != 0), a2, ($urandom_range(0, 7) != 0));
        end

        repeat (2) @(posedge clk);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
